// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported data RAM.
// The memory stage (D) normally wins. Fetch (F) is forced through after
// STARVE_LIMIT consecutive losses. Read data returns one cycle after the grant.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no response due this cycle
// RESP_F | fetch was granted last cycle; drive fetch response
// RESP_D | memory stage was granted last cycle; drive D response/ack
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [63:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [63:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [3:0]        starve_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_F = 2'd1,
        RESP_D = 2'd2
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic       err_q, err_d;
    logic       we_q, we_d;
    logic [3:0] starve_q, starve_d;

    logic f_in_range;
    logic d_in_range;
    logic f_force;

    assign f_in_range = (f_addr >> ADDR_W) == 64'd0;
    assign d_in_range = (d_addr >> ADDR_W) == 64'd0;
    assign f_force    = f_req && (starve_q == LIMIT);

    // Grant selection: D wins unless fetch has hit the starvation limit; nothing while in reset.
    always_comb begin
        d_gnt = 1'b0;
        f_gnt = 1'b0;
        if (rst_n) begin
            d_gnt = d_req && !f_force;
            f_gnt = f_req && !d_gnt;
        end
    end

    // RAM drive from the winning port; out-of-range accesses never reach the macro.
    always_comb begin
        ram_en    = (f_gnt && f_in_range) || (d_gnt && d_in_range);
        ram_we    = d_gnt && d_we && d_in_range;
        ram_addr  = d_gnt ? d_addr[ADDR_W-1:0] : f_addr[ADDR_W-1:0];
        ram_wdata = d_wdata;
    end

    // Starvation counter next value: count fetch losses, saturate at the limit.
    always_comb begin
        starve_d = 4'd0;
        if (f_req && !f_gnt) begin
            starve_d = (starve_q < LIMIT) ? starve_q + 4'd1 : starve_q;
        end
    end

    // Response FSM next state, remembering range error and write flag of the granted access.
    always_comb begin
        state_d = IDLE;
        err_d   = 1'b0;
        we_d    = 1'b0;
        if (f_gnt) begin
            state_d = RESP_F;
            err_d   = !f_in_range;
        end else if (d_gnt) begin
            state_d = RESP_D;
            err_d   = !d_in_range;
            we_d    = d_we;
        end
    end

    // State registers; reset drops any response in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            we_q     <= we_d;
            starve_q <= starve_d;
        end
    end

    // Response outputs; the non-responding port holds zeros.
    always_comb begin
        f_rvalid = (state_q == RESP_F);
        f_err    = f_rvalid && err_q;
        f_rdata  = (f_rvalid && !err_q) ? ram_rdata : '0;
        d_rvalid = (state_q == RESP_D);
        d_err    = d_rvalid && err_q;
        d_rdata  = (d_rvalid && !err_q && !we_q) ? ram_rdata : '0;
    end

    assign starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256x64 RAM.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [63:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [63:0] f_rdata;
    logic        f_err;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        d_err;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;
    logic [3:0]  starve_cnt;

    logic        init_mem;
    logic [63:0] mem [0:255];

    int total;
    int bad;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(64), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_gnt      (f_gnt),
        .f_rvalid   (f_rvalid),
        .f_rdata    (f_rdata),
        .f_err      (f_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .starve_cnt (starve_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM: read data (old contents) valid the cycle after ram_en.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
            ram_rdata <= 64'd0;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        init_mem = 1'b1;
        f_req    = 1'b1;
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_addr   = 64'h5;
        f_addr   = 64'h7;
        d_wdata  = 64'd0;

        // Reset held with both requests high
        repeat (3) @(posedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        #1;
        check("rst_f_gnt", f_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_f_rvalid", f_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_f_rdata", f_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_f_err", f_err, 0);
        check("rst_d_err", d_err, 0);
        check("rst_starve", starve_cnt, 0);

        // Release: D wins first, read of word 5
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_d_gnt", d_gnt, 1);
        check("rel_f_gnt", f_gnt, 0);
        check("rel_ram_en", ram_en, 1);
        @(posedge clk); #1;
        check("rel_d_rvalid", d_rvalid, 1);
        check("rel_d_rdata", d_rdata, 64'hA5A5_0000_0000_0005);
        check("rel_starve", starve_cnt, 1);

        // D write 0x10, then F read 0x10
        @(negedge clk);
        f_req   = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h10;
        d_wdata = 64'h1122_3344_5566_7788;
        #1;
        check("wr_d_gnt", d_gnt, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 8'h10);
        @(posedge clk); #1;
        check("wr_d_rvalid", d_rvalid, 1);
        check("wr_d_rdata", d_rdata, 0);
        check("wr_starve", starve_cnt, 0);
        @(negedge clk);
        d_req  = 1'b0;
        d_we   = 1'b0;
        f_req  = 1'b1;
        f_addr = 64'h10;
        #1;
        check("raw_f_gnt", f_gnt, 1);
        check("raw_ram_we", ram_we, 0);
        @(posedge clk); #1;
        check("raw_f_rvalid", f_rvalid, 1);
        check("raw_f_rdata", f_rdata, 64'h1122_3344_5566_7788);
        check("raw_f_err", f_err, 0);
        check("raw_d_rvalid", d_rvalid, 0);

        // Both requests for 12 cycles: D,D,D,D,F repeating
        @(negedge clk);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 64'h20;
        f_req  = 1'b1;
        f_addr = 64'h30;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("starve_f_gnt_%0d", i), f_gnt, (i % 5) == 4);
            check($sformatf("starve_d_gnt_%0d", i), d_gnt, (i % 5) != 4);
            @(posedge clk); #1;
            check($sformatf("starve_cnt_%0d", i), starve_cnt,
                  ((i % 5) == 4) ? 64'd0 : 64'((i % 5) + 1));
        end

        // D read out of range: granted, RAM untouched, error flagged, data zeroed
        @(negedge clk);
        f_req  = 1'b0;
        d_addr = 64'h100;
        #1;
        check("oor_d_gnt", d_gnt, 1);
        check("oor_ram_en", ram_en, 0);
        @(posedge clk); #1;
        check("oor_d_rvalid", d_rvalid, 1);
        check("oor_d_err", d_err, 1);
        check("oor_d_rdata", d_rdata, 0);

        // Write 0xFF in range, then suppressed write to 0x1FF, then read 0xFF
        @(negedge clk);
        d_we    = 1'b1;
        d_addr  = 64'hFF;
        d_wdata = 64'hCAFE_F00D_0000_00FF;
        @(posedge clk); #1;
        check("wff_d_err", d_err, 0);
        @(negedge clk);
        d_addr  = 64'h1FF;
        d_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        check("w1ff_d_gnt", d_gnt, 1);
        check("w1ff_ram_we", ram_we, 0);
        check("w1ff_ram_en", ram_en, 0);
        @(posedge clk); #1;
        check("w1ff_d_rvalid", d_rvalid, 1);
        check("w1ff_d_err", d_err, 1);
        @(negedge clk);
        d_we   = 1'b0;
        d_addr = 64'hFF;
        @(posedge clk); #1;
        check("rff_d_rdata", d_rdata, 64'hCAFE_F00D_0000_00FF);
        check("rff_d_err", d_err, 0);

        // F granted, then reset pulsed before the edge: response dropped
        @(negedge clk);
        d_req  = 1'b0;
        f_req  = 1'b1;
        f_addr = 64'h10;
        #1;
        check("rp_f_gnt", f_gnt, 1);
        #1;
        rst_n = 1'b0;
        f_req = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rp_f_rvalid0", f_rvalid, 0);
        check("rp_d_rvalid0", d_rvalid, 0);
        check("rp_f_rdata", f_rdata, 0);
        check("rp_starve", starve_cnt, 0);
        @(posedge clk); #1;
        check("rp_f_rvalid1", f_rvalid, 0);
        check("rp_state_idle", 64'(dut.state_q), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
